// File: rtl/vga_frame_sched.sv
// vga_frame_sched: frame scheduler and pixel compositor between game logic and
// the VGA timing driver.
//   - Detects the last visible pixel and raises a registered frame_end pulse.
//   - Opens one update window per frame (upd_req/upd_ack handshake) during
//     vertical blanking. Sprite positions are committed only on upd_ack, and
//     only while the window is open.
//   - Composites player / obstacle / background colours combinationally from
//     posx/posy. Reports player/obstacle overlap once per frame.
// Ports:
//   vga_clk, rst            pixel clock, async active-high reset
//   posx, posy              raster position from driver (0 outside display)
//   pause                   suppresses new update requests
//   clr_ovr                 clears the sticky overrun flag
//   upd_ack, new_*          ack pulse with the next sprite positions
//   upd_req                 update request to game logic
//   rgb_data                composited pixel colour
//   frame_cnt               completed frame count (wraps)
//   collide                 overlap seen during the last completed frame
//   overrun                 sticky: a window closed without an ack
module vga_frame_sched #(
    parameter int         H_LAST   = 640,
    parameter int         V_LAST   = 490,
    parameter int         SPR_W    = 16,
    parameter int         SPR_H    = 16,
    parameter int         WINDOW   = 24000,
    parameter logic [2:0] P_COLOR  = 3'b010,
    parameter logic [2:0] O_COLOR  = 3'b100,
    parameter logic [2:0] BG_COLOR = 3'b001
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [9:0]  posx,
    input  logic [9:0]  posy,
    input  logic        pause,
    input  logic        clr_ovr,
    input  logic        upd_ack,
    input  logic [9:0]  new_px,
    input  logic [9:0]  new_py,
    input  logic [9:0]  new_ox,
    input  logic [9:0]  new_oy,
    output logic        upd_req,
    output logic [2:0]  rgb_data,
    output logic [15:0] frame_cnt,
    output logic        collide,
    output logic        overrun
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic [CW-1:0] win_cnt;
    logic [9:0]    px, py, ox, oy;
    logic          frame_end;
    logic          hit;

    logic in_p, in_o, visible, overlap, last_px, timeout;

    // Box tests widened to 11 bits so a box placed near 1023 does not wrap.
    assign in_p = ({1'b0, posx} >= {1'b0, px}) && ({1'b0, posx} < ({1'b0, px} + 11'(SPR_W))) &&
                  ({1'b0, posy} >= {1'b0, py}) && ({1'b0, posy} < ({1'b0, py} + 11'(SPR_H)));
    assign in_o = ({1'b0, posx} >= {1'b0, ox}) && ({1'b0, posx} < ({1'b0, ox} + 11'(SPR_W))) &&
                  ({1'b0, posy} >= {1'b0, oy}) && ({1'b0, posy} < ({1'b0, oy} + 11'(SPR_H)));

    assign visible = (posx != 10'd0) && (posy != 10'd0) &&
                     (posx <= 10'(H_LAST)) && (posy <= 10'(V_LAST));
    assign overlap = in_p && in_o && visible;
    assign last_px = (posx == 10'(H_LAST)) && (posy == 10'(V_LAST));
    // Last cycle of the window; an ack in the same cycle takes precedence.
    assign timeout = (state == REQ) && (win_cnt == CW'(WINDOW - 1));

    always_comb begin
        rgb_data = BG_COLOR;
        if (posx == 10'd0 || posy == 10'd0) rgb_data = 3'b000;
        else if (in_p)                      rgb_data = P_COLOR;
        else if (in_o)                      rgb_data = O_COLOR;
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_cnt   <= '0;
            upd_req   <= 1'b0;
            px        <= '0;
            py        <= '0;
            ox        <= '0;
            oy        <= '0;
            frame_end <= 1'b0;
            frame_cnt <= '0;
            collide   <= 1'b0;
            hit       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_end <= last_px;

            // frame_cnt and collide change on the same edge that raises
            // frame_end, so the overlap of the last pixel itself still counts.
            if (last_px) begin
                frame_cnt <= frame_cnt + 16'd1;
                collide   <= hit || overlap;
                hit       <= 1'b0;
            end else if (overlap) begin
                hit <= 1'b1;
            end

            // Set wins over clear.
            overrun <= (timeout && !upd_ack) || (overrun && !clr_ovr);

            case (state)
                IDLE: begin
                    upd_req <= 1'b0;
                    win_cnt <= '0;
                    if (frame_end && !pause) begin
                        state   <= REQ;
                        upd_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (upd_ack) begin
                        px      <= new_px;
                        py      <= new_py;
                        ox      <= new_ox;
                        oy      <= new_oy;
                        upd_req <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout) begin
                        upd_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    upd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_sched.sv
// Self-checking bench for vga_frame_sched. A short WINDOW keeps frames cheap;
// frames are synthesised by visiting a handful of pixels, the last visible
// pixel, then a blanking stretch longer than WINDOW.
module tb_vga_frame_sched;

    localparam int         H_LAST = 640;
    localparam int         V_LAST = 490;
    localparam int         SPR_W  = 16;
    localparam int         SPR_H  = 16;
    localparam int         WINDOW = 40;
    localparam logic [2:0] P_C    = 3'b010;
    localparam logic [2:0] O_C    = 3'b100;
    localparam logic [2:0] B_C    = 3'b001;

    logic        vga_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [9:0]  posx = '0, posy = '0;
    logic        pause = 1'b0, clr_ovr = 1'b0, upd_ack = 1'b0;
    logic [9:0]  new_px = '0, new_py = '0, new_ox = '0, new_oy = '0;
    logic        upd_req;
    logic [2:0]  rgb_data;
    logic [15:0] frame_cnt;
    logic        collide, overrun;

    vga_frame_sched #(
        .H_LAST(H_LAST), .V_LAST(V_LAST), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .WINDOW(WINDOW), .P_COLOR(P_C), .O_COLOR(O_C), .BG_COLOR(B_C)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .posx(posx), .posy(posy),
        .pause(pause), .clr_ovr(clr_ovr), .upd_ack(upd_ack),
        .new_px(new_px), .new_py(new_py), .new_ox(new_ox), .new_oy(new_oy),
        .upd_req(upd_req), .rgb_data(rgb_data), .frame_cnt(frame_cnt),
        .collide(collide), .overrun(overrun)
    );

    always #5 vga_clk = ~vga_clk;

    int nvec = 0, nfail = 0, frames_run = 0;

    // Reference model: transaction-level view using absolute edge stamps.
    int     m_px, m_py, m_ox, m_oy, m_cnt;
    bit     m_fe, m_req, m_ovr, m_col, m_hit;
    longint m_edge = 0, m_deadline = 0;

    typedef struct { int x; int y; logic [2:0] rgb; } pix_vec_t;
    pix_vec_t tbl[8];

    function automatic bit in_box(int x, int y, int bx, int by);
        return x >= bx && x < bx + SPR_W && y >= by && y < by + SPR_H;
    endfunction

    function automatic bit vis(int x, int y);
        return x >= 1 && x <= H_LAST && y >= 1 && y <= V_LAST;
    endfunction

    function automatic logic [2:0] ref_rgb(int x, int y);
        if (x == 0 || y == 0)           return 3'b000;
        if (in_box(x, y, m_px, m_py))   return P_C;
        if (in_box(x, y, m_ox, m_oy))   return O_C;
        return B_C;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_ox = 0; m_oy = 0; m_cnt = 0;
        m_fe = 0; m_req = 0; m_ovr = 0; m_col = 0; m_hit = 0;
    endtask

    // Applies one clock edge to the model using the inputs present before it.
    task automatic model_edge();
        int x = int'(posx);
        int y = int'(posy);
        bit ov, last, set_o;
        m_edge++;
        ov    = in_box(x, y, m_px, m_py) && in_box(x, y, m_ox, m_oy) && vis(x, y);
        last  = (x == H_LAST) && (y == V_LAST);
        set_o = 0;
        if (m_req) begin
            if (upd_ack) begin
                m_px = int'(new_px); m_py = int'(new_py);
                m_ox = int'(new_ox); m_oy = int'(new_oy);
                m_req = 0;
            end else if (m_edge == m_deadline) begin
                m_req = 0; set_o = 1;
            end
        end else if (m_fe && !pause) begin
            m_req = 1; m_deadline = m_edge + WINDOW;
        end
        m_ovr = set_o || (m_ovr && !clr_ovr);
        if (last) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_col = m_hit || ov;
            m_hit = 0;
        end else if (ov) begin
            m_hit = 1;
        end
        m_fe = last;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        model_edge();
        #1;
        chk("upd_req",   32'(upd_req),   32'(m_req));
        chk("rgb",       32'(rgb_data),  32'(ref_rgb(int'(posx), int'(posy))));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("collide",   32'(collide),   32'(m_col));
        chk("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    task automatic set_pos(input int a, input int b, input int c, input int d);
        new_px = 10'(a); new_py = 10'(b); new_ox = 10'(c); new_oy = 10'(d);
    endtask

    // One frame: a few visible pixels, the last pixel, then blanking. ack_at /
    // clr_at pick which high cycle of upd_req (0-based) gets the pulse.
    task automatic run_frame(input int ack_at, input int clr_at, output int hi);
        int xs[6] = '{5, 100, 110, 100, 315, 316};
        int ys[6] = '{5, 100, 110, 200, 215, 200};
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            posx = 10'(xs[i]); posy = 10'(ys[i]); step();
        end
        posx = 10'(H_LAST); posy = 10'(V_LAST); step();
        frames_run++;
        for (int c = 0; c < WINDOW + 12; c++) begin
            posx = '0; posy = '0;
            upd_ack = upd_req && (hi == ack_at);
            clr_ovr = upd_req && (hi == clr_at);
            if (upd_req) hi++;
            step();
        end
        upd_ack = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic pix(input string name, input int x, input int y, input logic [2:0] exp);
        posx = 10'(x); posy = 10'(y); step();
        chk(name, 32'(rgb_data), 32'(exp));
    endtask

    initial begin
        int hi, seen;
        tbl[0] = '{100, 200, 3'b010};
        tbl[1] = '{315, 215, 3'b100};
        tbl[2] = '{316, 200, 3'b001};
        tbl[3] = '{0,   200, 3'b000};
        tbl[4] = '{115, 215, 3'b010};
        tbl[5] = '{99,  200, 3'b001};
        tbl[6] = '{300, 200, 3'b100};
        tbl[7] = '{314, 216, 3'b001};

        // Reset state
        model_reset();
        #12 rst = 1'b0;
        #1;
        chk("rst_upd_req",   32'(upd_req),   32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_collide",   32'(collide),   32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        posx = 10'd5; posy = 10'd5; #1;
        chk("rst_rgb_5_5", 32'(rgb_data), 32'(3'b010));
        posx = 10'd100; posy = 10'd100; #1;
        chk("rst_rgb_100_100", 32'(rgb_data), 32'(3'b001));

        // Two frames with no ack
        run_frame(-1, -1, hi);
        chk("req_len_f1", 32'(hi), 32'(WINDOW));
        chk("overrun_f1", 32'(overrun), 32'd1);
        run_frame(-1, -1, hi);
        chk("req_len_f2", 32'(hi), 32'(WINDOW));
        chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
        pix("noack_5_5", 5, 5, 3'b010);
        pix("noack_100_100", 100, 100, 3'b001);

        // Ack 10 cycles into the window, then the pixel table
        set_pos(100, 200, 300, 200);
        run_frame(10, -1, hi);
        chk("req_len_ack", 32'(hi), 32'd11);
        for (int i = 0; i < 8; i++) begin
            posx = 10'(tbl[i].x); posy = 10'(tbl[i].y); step();
            chk($sformatf("tbl%0d", i), 32'(rgb_data), 32'(tbl[i].rgb));
        end

        // Overlap, then move the obstacle away
        set_pos(100, 100, 108, 108);
        run_frame(10, -1, hi);
        chk("collide_pre", 32'(collide), 32'd0);
        pix("ovl_110_110", 110, 110, 3'b010);
        set_pos(100, 100, 400, 400);
        run_frame(10, -1, hi);
        chk("collide_set", 32'(collide), 32'd1);
        run_frame(-1, -1, hi);
        chk("collide_clr", 32'(collide), 32'd0);

        // Pause over 3 frames plus a spurious ack in IDLE
        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, -1, hi);
            chk("pause_no_req", 32'(hi), 32'd0);
        end
        chk("pause_frame_cnt", 32'(frame_cnt), 32'(frames_run));
        set_pos(500, 500, 500, 500);
        upd_ack = 1'b1; step(); upd_ack = 1'b0;
        pix("spurious_ack", 100, 100, 3'b010);
        pause = 1'b0;

        // Ack on the timeout cycle
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        set_pos(200, 300, 50, 50);
        run_frame(WINDOW - 1, -1, hi);
        chk("ack_tmo_ovr", 32'(overrun), 32'd0);
        pix("ack_tmo_p", 200, 300, 3'b010);
        pix("ack_tmo_o", 50, 50, 3'b100);

        // Clear on the timeout cycle: set wins
        run_frame(-1, WINDOW - 1, hi);
        chk("clr_tmo_ovr", 32'(overrun), 32'd1);

        // Reset in the middle of a window
        posx = 10'(H_LAST); posy = 10'(V_LAST); step();
        seen = 0;
        posx = '0; posy = '0;
        for (int c = 0; c < WINDOW && seen < 5; c++) begin
            step();
            if (upd_req) seen++;
        end
        chk("rst_req_seen", 32'(seen), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_upd_req",   32'(upd_req),   32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_collide",   32'(collide),   32'd0);
        chk("mid_rst_overrun",   32'(overrun),   32'd0);
        model_reset();
        frames_run = 0;
        posx = 10'd300; posy = 10'd200; #1;
        chk("mid_rst_rgb", 32'(rgb_data), 32'(3'b001));
        #1 rst = 1'b0;
        run_frame(-1, -1, hi);
        chk("post_rst_req_len", 32'(hi), 32'(WINDOW));
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomised frames against the model
        for (int f = 0; f < 30; f++) begin
            pause = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    posx = 10'($urandom_range(0, 1023)); posy = 10'($urandom_range(0, 1023));
                end else begin
                    posx = 10'($urandom_range(0, 80)); posy = 10'($urandom_range(0, 80));
                end
                set_pos($urandom_range(0, 60), $urandom_range(0, 60),
                        $urandom_range(0, 60), $urandom_range(0, 60));
                upd_ack = ($urandom_range(0, 15) == 0);
                clr_ovr = ($urandom_range(0, 15) == 0);
                step();
            end
            upd_ack = 1'b0; clr_ovr = 1'b0;
            posx = 10'(H_LAST); posy = 10'(V_LAST); step();
            for (int c = 0; c < WINDOW + 5; c++) begin
                posx = '0; posy = '0;
                if ($urandom_range(0, 7) == 0)
                    set_pos($urandom_range(1000, 1023), $urandom_range(1000, 1023),
                            $urandom_range(0, 60), $urandom_range(0, 60));
                else
                    set_pos($urandom_range(0, 60), $urandom_range(0, 60),
                            $urandom_range(0, 60), $urandom_range(0, 60));
                upd_ack = ($urandom_range(0, 39) == 0);
                clr_ovr = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) == 0) pause = ~pause;
                step();
            end
            upd_ack = 1'b0; clr_ovr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/vga_frame_sched.md
# vga_frame_sched

Frame scheduler and pixel compositor that sits between the game logic and the VGA timing driver. It tracks raster position from the driver's `posx`/`posy`, opens one update window per frame in vertical blanking, and runs a req/ack handshake with the game logic. Sprite positions are committed only inside that window, so there is no tearing. Each pixel is composited from a player box, an obstacle box and the background, and player/obstacle overlap is reported once per frame.

## Interface
Parameters:
- `H_LAST`, 640: last visible `posx` value (visible `posx` range is 1..H_LAST).
- `V_LAST`, 490: last visible `posy` value (visible `posy` range is 1..V_LAST).
- `SPR_W`, 16: sprite box width in pixels, used for both sprites.
- `SPR_H`, 16: sprite box height in pixels, used for both sprites.
- `WINDOW`, 24000: update-window length in `vga_clk` cycles; must be less than the blanking length of 28160.
- `P_COLOR`, 3'b010: player colour.
- `O_COLOR`, 3'b100: obstacle colour.
- `BG_COLOR`, 3'b001: background colour.

Ports (direction, width, meaning):
- `vga_clk`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `posx`, in, 10: driver x; 0 outside the display area.
- `posy`, in, 10: driver y; 0 outside the display area.
- `pause`, in, 1: suppresses new update requests.
- `clr_ovr`, in, 1: clears `overrun`.
- `upd_ack`, in, 1: one-cycle pulse; the four `new_*` buses are valid in the same cycle.
- `new_px`, `new_py`, `new_ox`, `new_oy`, in, 10 each: next player and obstacle positions (box top-left corner).
- `upd_req`, out, 1: update request to the game logic.
- `rgb_data`, out, 3: composited pixel colour, fed to the driver.
- `frame_cnt`, out, 16: count of completed frames.
- `collide`, out, 1: player and obstacle overlapped during the last completed frame.
- `overrun`, out, 1: sticky flag; a window closed without an ack.

## Operation
- `frame_end`: internal one-cycle pulse, registered, in the cycle after `posx==H_LAST && posy==V_LAST` is observed.
- `frame_cnt`: increments on `frame_end`; wraps from 0xFFFF to 0.

FSM states:
- IDLE
  - On `frame_end`: go to REQ if `pause==0`.
  - If `pause==1`: stay in IDLE; no request is issued for that frame.
- REQ
  - `upd_req` is 1; a window counter starts at 0 and increments every cycle.
  - `upd_ack` seen: latch `new_px/py/ox/oy` into the active position registers in that same edge, drop `upd_req` the next cycle, go to IDLE.
  - Counter reaches WINDOW-1 with no ack: drop `upd_req`, set `overrun`, go to IDLE. The old positions are kept.
  - Ack and timeout in the same cycle: the ack wins and `overrun` is not set.
- `upd_ack` in IDLE (late or spurious): ignored; positions are unchanged.
- `pause` rising while in REQ: does not abort the current window.
- `overrun`: cleared by `clr_ovr`. If set and clear occur in the same cycle, set wins.

Compositor (combinational from `posx`/`posy` and the active registers; zero added latency):
- `inP`: `posx >= px && posx < px+SPR_W && posy >= py && posy < py+SPR_H`.
- `inO`: the same test against `ox`/`oy`.
- Sums are computed at 11 bits, so boxes near 1023 do not wrap.
- `rgb_data` selection:
  - `posx==0 || posy==0`: 0.
  - Otherwise `inP`: P_COLOR.
  - Otherwise `inO`: O_COLOR.
  - Otherwise: BG_COLOR.
- Collision:
  - Internal `hit` flag is set on any cycle where `inP && inO` and the pixel is visible.
  - On `frame_end`: `collide <= hit` (or `inP && inO` if a hit occurs that same cycle), and `hit` is cleared.

## Timing
Reset values:
- `upd_req` 0, `frame_cnt` 0, `collide` 0, `overrun` 0, `hit` 0.
- px, py, ox, oy all 0. The player box therefore covers `posx` 1..15, `posy` 1..15 until the first update, because the player has priority.
- FSM in IDLE.

Cycle timing:
- `upd_req` rises 1 cycle after `frame_end`, i.e. 2 cycles after the last visible pixel.
- Ack at edge N: the new positions drive `rgb_data` from cycle N+1.
- Positions never change while a pixel is visible, provided WINDOW < blanking length.
- `collide` and `frame_cnt` update in the same cycle as `frame_end`.

Reset mid-window: `upd_req` drops asynchronously and no partial latch occurs.

## Test plan
- Reset, then run 2 frames with no ack:
  - `frame_cnt` = 2.
  - `upd_req` is high for exactly 24000 cycles per frame.
  - `overrun` = 1 after the first frame.
  - `rgb_data` = 3'b010 at (5,5) and 3'b001 at (100,100).
- Ack 10 cycles after `upd_req` with px=100, py=200, ox=300, oy=200:
  - Next frame: (100,200) = 3'b010, (315,215) = 3'b100, (316,200) = 3'b001, (0,200) = 0.
- Overlap px=100, py=100, ox=108, oy=108:
  - (110,110) = 3'b010.
  - `collide` = 1 at the following `frame_end`.
  - After moving the obstacle to 400, `collide` returns to 0 one frame later.
- `pause`=1 over 3 frames:
  - No `upd_req`; `frame_cnt` still advances by 3.
  - An ack pulse injected in IDLE leaves the positions unchanged.
- Ack in the same cycle as the timeout:
  - Positions latch and `overrun` stays 0.
- `clr_ovr` in the same cycle as a new timeout:
  - `overrun` remains 1.
- Assert `rst` while in REQ:
  - All outputs return to their reset values immediately.
  - FSM resumes from IDLE.
